// File: rtl/ncl_dr_receiver_pkg.sv
// Shared NCL definitions: dual-rail bit type, rail code constants,
// per-bit classification, receiver FSM states and a classify helper.
package ncl_dr_receiver_pkg;

  typedef struct packed {
    logic rail1;
    logic rail0;
  } dual_rail_logic;

  localparam dual_rail_logic DR_NULL    = 2'b00;
  localparam dual_rail_logic DR_ONE     = 2'b10;
  localparam dual_rail_logic DR_ZERO    = 2'b01;
  localparam dual_rail_logic DR_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    DRC_NULL,
    DRC_DATA,
    DRC_ILLEGAL
  } dr_class_e;

  typedef enum logic [1:0] {
    WAIT_DATA,
    HOLD,
    WAIT_NULL,
    FAULT
  } state_e;

  function automatic dr_class_e dr_classify(input dual_rail_logic b);
    case (b)
      DR_ONE, DR_ZERO: return DRC_DATA;
      DR_NULL:         return DRC_NULL;
      default:         return DRC_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/ncl_dr_receiver_sync.sv
// ncl_dr_sync: brings one asynchronous dual-rail bit into the clk domain
// through SYNC_STAGES flops per rail, then classifies the synchronized code.
// Ports:
//   clk, rst_n   clock and synchronous active-low reset (flops clear to NULL)
//   din_i        raw dual-rail bit from the NCL datapath
//   cls_o        NULL / DATA / ILLEGAL class of the synchronized bit
//   value_o      synchronized rail1 (the decoded value when DATA)
module ncl_dr_sync
  import ncl_dr_receiver_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  dual_rail_logic din_i,
  output dr_class_e      cls_o,
  output logic           value_o
);

  logic [SYNC_STAGES-1:0] rail1_q;
  logic [SYNC_STAGES-1:0] rail0_q;
  dual_rail_logic         synced;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rail1_q <= '0;
      rail0_q <= '0;
    end else begin
      rail1_q <= {rail1_q[SYNC_STAGES-2:0], din_i.rail1};
      rail0_q <= {rail0_q[SYNC_STAGES-2:0], din_i.rail0};
    end
  end

  assign synced  = {rail1_q[SYNC_STAGES-1], rail0_q[SYNC_STAGES-1]};
  assign cls_o   = dr_classify(synced);
  assign value_o = synced.rail1;

endmodule

// File: rtl/ncl_dr_receiver.sv
// ncl_dr_receiver: NCL-to-synchronous boundary. Synchronizes a dual-rail
// word, waits for a stable complete DATA wavefront, presents it with a
// valid/ready handshake, then requests NULL and waits for the empty
// wavefront. Illegal codes and stalled wavefronts lock into FAULT.
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   din           asynchronous dual-rail word
//   ko            NCL request (1 = DATA, 0 = NULL)
//   dout          decoded word, dout_valid qualifies it
//   dout_ready    downstream accept
//   err_illegal   sticky: 11 code seen while waiting for a wavefront
//   err_timeout   sticky: wavefront took TIMEOUT cycles
module ncl_dr_receiver
  import ncl_dr_receiver_pkg::*;
#(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  dual_rail_logic [WIDTH-1:0] din,
  output logic                       ko,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       err_illegal,
  output logic                       err_timeout
);

  localparam logic [15:0] TO_LIM = 16'(TIMEOUT);

  dr_class_e        cls [WIDTH];
  logic [WIDTH-1:0] word;
  logic             all_data, all_null, any_ill;

  for (genvar g = 0; g < WIDTH; g++) begin : g_sync
    ncl_dr_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .din_i   (din[g]),
      .cls_o   (cls[g]),
      .value_o (word[g])
    );
  end

  always_comb begin
    all_data = 1'b1;
    all_null = 1'b1;
    any_ill  = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      all_data &= (cls[i] == DRC_DATA);
      all_null &= (cls[i] == DRC_NULL);
      any_ill  |= (cls[i] == DRC_ILLEGAL);
    end
  end

  state_e           state_q, state_d;
  logic [15:0]      cnt_q, cnt_d, cnt_inc;
  logic             seen_q, seen_d;   // previous cycle already met the condition
  logic [WIDTH-1:0] prev_q, prev_d;   // value seen on that previous cycle
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d, ko_q, ko_d, ill_q, ill_d, tmo_q, tmo_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    seen_d  = seen_q;
    prev_d  = prev_q;
    dout_d  = dout_q;
    ill_d   = ill_q;
    tmo_d   = tmo_q;
    cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    case (state_q)
      WAIT_DATA: begin
        if (any_ill) begin
          ill_d   = 1'b1;
          state_d = FAULT;
        end else if (all_data && seen_q && (word == prev_q)) begin
          dout_d  = word;
          state_d = HOLD;
        end else if (cnt_inc >= TO_LIM) begin
          tmo_d   = 1'b1;
          state_d = FAULT;
        end else begin
          // a changed complete value simply becomes the new first sighting
          seen_d = all_data;
          prev_d = word;
        end
      end
      HOLD: begin
        if (dout_ready) state_d = WAIT_NULL;
      end
      WAIT_NULL: begin
        if (any_ill) begin
          ill_d   = 1'b1;
          state_d = FAULT;
        end else if (all_null && seen_q) begin
          state_d = WAIT_DATA;
        end else if (cnt_inc >= TO_LIM) begin
          tmo_d   = 1'b1;
          state_d = FAULT;
        end else begin
          seen_d = all_null;
        end
      end
      default: ;
    endcase

    if (state_d != state_q) begin
      cnt_d  = '0;
      seen_d = 1'b0;
    end else if (state_q == WAIT_DATA || state_q == WAIT_NULL) begin
      cnt_d = cnt_inc;
    end

    valid_d = (state_d == HOLD);
    ko_d    = (state_d == WAIT_DATA) || (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_DATA;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      prev_q  <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ko_q    <= 1'b1;
      ill_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      prev_q  <= prev_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ko_q    <= ko_d;
      ill_q   <= ill_d;
      tmo_q   <= tmo_d;
    end
  end

  assign ko          = ko_q;
  assign dout        = dout_q;
  assign dout_valid  = valid_q;
  assign err_illegal = ill_q;
  assign err_timeout = tmo_q;

endmodule

// File: tb/tb_ncl_dr_receiver.sv
module tb_ncl_dr_receiver;

  localparam int W = 6;
  localparam int S = 2;

  logic          clk = 1'b0;
  logic          rst_n, rst2_n;
  logic [2*W-1:0] din, din2;
  logic          ko, ko2, dout_valid, valid2, dout_ready, ready2;
  logic          err_illegal, err_timeout, ill2, tmo2;
  logic [W-1:0]  dout, dout2;

  always #5 clk = ~clk;

  ncl_dr_receiver #(.WIDTH(W), .SYNC_STAGES(S), .TIMEOUT(255)) u_dut (
    .clk(clk), .rst_n(rst_n), .din(din), .ko(ko), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  ncl_dr_receiver #(.WIDTH(W), .SYNC_STAGES(S), .TIMEOUT(8)) u_to (
    .clk(clk), .rst_n(rst2_n), .din(din2), .ko(ko2), .dout(dout2),
    .dout_valid(valid2), .dout_ready(ready2),
    .err_illegal(ill2), .err_timeout(tmo2)
  );

  int chk = 0;
  int errs = 0;
  int xfers = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2*W-1:0] raw;
    logic [W-1:0]   exp;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // dual-rail encoding of a value; bits outside mask are NULL
  function automatic logic [2*W-1:0] enc(input logic [W-1:0] v, input logic [W-1:0] m);
    logic [2*W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++)
      if (m[i]) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  function automatic bit cond(input int sel);
    case (sel)
      0: return dout_valid;
      1: return ko;
      2: return !ko;
      3: return err_illegal;
      4: return tmo2;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int bound, input string name, output int n);
    n = 0;
    while (!cond(sel) && n < bound) begin
      tick();
      n++;
    end
    if (!cond(sel)) begin
      chk++;
      errs++;
      $display("FAIL %s: condition not reached within %0d cycles", name, bound);
    end
  endtask

  // transfer scoreboard and hold-stability monitor
  logic         hold_prev = 1'b0;
  logic [W-1:0] last_dout = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev && dout_valid) check("hold_stable", int'(dout), int'(last_dout));
      if (dout_valid && dout_ready) begin
        xfers++;
        if (exp_q.size() == 0) begin
          chk++;
          errs++;
          $display("FAIL unexpected_xfer: actual=%0h required=no transfer", dout);
        end else begin
          check("xfer_data", int'(dout), int'(exp_q.pop_front()));
        end
      end
    end
    hold_prev = rst_n && dout_valid && !dout_ready;
    last_dout = dout;
  end

  initial begin
    int n, x0;
    logic [W-1:0] v, m;
    int arr[W];

    tbl[0] = '{12'b01_01_01_01_01_10, 6'b000001};
    tbl[1] = '{12'b10_01_01_10_01_01, 6'b100100};
    tbl[2] = '{12'b10_10_10_10_10_10, 6'b111111};
    tbl[3] = '{12'b01_01_01_01_01_01, 6'b000000};
    tbl[4] = '{12'b10_01_10_01_10_01, 6'b101010};
    tbl[5] = '{12'b01_10_01_10_01_10, 6'b010101};

    rst_n = 1'b0; rst2_n = 1'b0; din = '0; din2 = '0;
    dout_ready = 1'b0; ready2 = 1'b0;
    tick(); tick();
    check("rst_ko", int'(ko), 1);
    check("rst_valid", int'(dout_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_illegal", int'(err_illegal), 0);
    check("rst_timeout", int'(err_timeout), 0);
    rst_n = 1'b1;

    // table: decode, latency, one-cycle pulse, NULL turnaround
    for (int i = 0; i < 6; i++) begin
      dout_ready = 1'b1;
      exp_q.push_back(tbl[i].exp);
      din = tbl[i].raw;
      wait_for(0, 20, "tbl_valid", n);
      check("tbl_latency", n, S + 2);
      check("tbl_dout", int'(dout), int'(tbl[i].exp));
      check("tbl_ko_hold", int'(ko), 1);
      tick();
      check("tbl_pulse", int'(dout_valid), 0);
      check("tbl_ko_null", int'(ko), 0);
      din = '0;
      wait_for(1, 20, "tbl_ko_ret", n);
      check("tbl_null_lat", int'(n <= S + 2), 1);
    end

    // backpressure with illegal then NULL codes arriving during HOLD
    dout_ready = 1'b0;
    din = enc(6'b110011, '1);
    wait_for(0, 20, "hold_valid_wait", n);
    check("hold_latency", n, S + 2);
    for (int c = 0; c < 20; c++) begin
      if (c == 5) din[7:6] = 2'b11;
      if (c == 10) din = '0;
      check("hold_valid", int'(dout_valid), 1);
      check("hold_dout", int'(dout), 'h33);
      check("hold_ko", int'(ko), 1);
      check("hold_no_illegal", int'(err_illegal), 0);
      tick();
    end
    x0 = xfers;
    exp_q.push_back(6'b110011);
    dout_ready = 1'b1;
    tick(); tick(); tick();
    check("hold_one_xfer", xfers - x0, 1);
    check("hold_after_valid", int'(dout_valid), 0);
    check("hold_after_ko", int'(ko), 1);

    // reset while holding drops the word; DATA still present at release
    dout_ready = 1'b0;
    din = enc(6'b001011, '1);
    wait_for(0, 20, "rsth_valid", n);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    check("rsth_valid", int'(dout_valid), 0);
    check("rsth_dout", int'(dout), 0);
    check("rsth_ko", int'(ko), 1);
    tick();
    exp_q.push_back(6'b001011);
    dout_ready = 1'b1;
    rst_n = 1'b1;
    wait_for(0, 20, "rsth_redecode", n);
    check("rsth_latency", n, S + 2);
    tick();
    din = '0;
    wait_for(1, 20, "rsth_ko_ret", n);

    // skewed arrival, one bit per cycle
    m = '0;
    exp_q.push_back(6'b011010);
    for (int i = 0; i < W; i++) begin
      m[i] = 1'b1;
      din = enc(6'b011010, m);
      tick();
    end
    wait_for(0, 20, "skew_valid", n);
    check("skew_dout", int'(dout), 'h1a);
    check("skew_illegal", int'(err_illegal), 0);
    check("skew_timeout", int'(err_timeout), 0);
    tick();
    din = '0;
    wait_for(1, 20, "skew_ko_ret", n);

    // complete value changes after one cycle: only the second is delivered
    din = enc(6'b111000, '1);
    tick();
    exp_q.push_back(6'b000111);
    din = enc(6'b000111, '1);
    wait_for(0, 20, "chg_valid", n);
    check("chg_dout", int'(dout), 'h07);
    check("chg_illegal", int'(err_illegal), 0);
    tick();
    din = '0;
    wait_for(1, 20, "chg_ko_ret", n);

    // randomized words with skew and random backpressure
    for (int k = 0; k < 40; k++) begin
      v = 6'($urandom);
      exp_q.push_back(v);
      for (int i = 0; i < W; i++) arr[i] = int'($urandom_range(0, 3));
      for (int c = 0; c < 4; c++) begin
        m = '0;
        for (int i = 0; i < W; i++) m[i] = (arr[i] <= c);
        din = enc(v, m);
        dout_ready = 1'($urandom_range(0, 1));
        tick();
      end
      n = 0;
      while (ko && n < 300) begin
        dout_ready = 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      check("rand_ko_drop", int'(ko), 0);
      for (int i = 0; i < W; i++) arr[i] = int'($urandom_range(0, 3));
      for (int c = 0; c < 4; c++) begin
        m = '0;
        for (int i = 0; i < W; i++) m[i] = (arr[i] > c);
        din = enc(v, m);
        tick();
      end
      wait_for(1, 20, "rand_ko_ret", n);
      check("rand_illegal", int'(err_illegal), 0);
      check("rand_timeout", int'(err_timeout), 0);
    end

    // illegal code in WAIT_DATA locks into FAULT until reset
    dout_ready = 1'b1;
    din = '0;
    din[7:6] = 2'b11;
    wait_for(3, 20, "ill_wait", n);
    check("ill_latency", n, S + 1);
    check("ill_ko", int'(ko), 0);
    check("ill_valid", int'(dout_valid), 0);
    check("ill_no_timeout", int'(err_timeout), 0);
    din = enc(6'b101101, '1);
    for (int c = 0; c < 10; c++) tick();
    check("fault_ko", int'(ko), 0);
    check("fault_valid", int'(dout_valid), 0);
    check("fault_illegal", int'(err_illegal), 1);
    rst_n = 1'b0;
    din = '0;
    tick();
    check("fault_rst_ko", int'(ko), 1);
    check("fault_rst_illegal", int'(err_illegal), 0);
    check("fault_rst_dout", int'(dout), 0);
    rst_n = 1'b1;
    tick();
    check("fault_rel_ko", int'(ko), 1);

    // TIMEOUT=8 instance held PARTIAL (bit5 NULL)
    din2 = enc(6'b010101, 6'b011111);
    tick();
    rst2_n = 1'b1;
    wait_for(4, 30, "to_wait", n);
    check("to_cycles", n, 8);
    check("to_illegal", int'(ill2), 0);
    check("to_ko", int'(ko2), 0);
    check("to_valid", int'(valid2), 0);
    check("to_dout", int'(dout2), 0);

    tick();
    check("sb_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end

endmodule

// File: doc/ncl_dr_receiver.md
NCL_DR_RECEIVER -- requirements
Module: ncl_dr_receiver

Interface
REQ-001 SHALL have parameter WIDTH, default 6, meaning the number of dual-rail bits received (the 3x3 product).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning the flop depth of the per-rail synchronizer (minimum 2).
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning the cycles allowed per DATA or NULL wavefront before fault.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset; it is synchronous and active-low.
REQ-006 SHALL have port din, input, dual_rail_logic [WIDTH-1:0], the asynchronous dual-rail word from the NCL datapath (rail1/rail0 per bit).
REQ-007 SHALL have port ko, output, 1, the NCL request: 1 = request DATA, 0 = request NULL.
REQ-008 SHALL have port dout, output, WIDTH, the decoded binary word.
REQ-009 SHALL have port dout_valid, output, 1, meaning dout holds a decoded word.
REQ-010 SHALL have port dout_ready, input, 1, the downstream acceptance; a transfer occurs when dout_valid and dout_ready are both 1 on an edge.
REQ-011 SHALL have port err_illegal, output, 1, a sticky flag set when an 11 rail code is seen.
REQ-012 SHALL have port err_timeout, output, 1, a sticky flag set when a wavefront exceeds TIMEOUT.

Function
REQ-013 SHALL pass every rail of din through SYNC_STAGES flops; all decisions use only synchronized rails.
REQ-014 SHALL classify each synchronized bit as follows: 10 = DATA 1, 01 = DATA 0, 00 = NULL, 11 = ILLEGAL.
REQ-015 SHALL define the word as COMPLETE when all bits are DATA, EMPTY when all bits are NULL, and PARTIAL otherwise.
REQ-016 SHALL implement the FSM states WAIT_DATA, HOLD, WAIT_NULL and FAULT.
REQ-017 In WAIT_DATA: ko=1; COMPLETE with an identical decoded value on 2 consecutive cycles SHALL load dout on the second cycle and go to HOLD.
REQ-018 A COMPLETE word whose value changes between cycles SHALL restart the 2-cycle check without error.
REQ-019 In HOLD: ko=1 and dout_valid=1; dout SHALL be stable; on a transfer the FSM goes to WAIT_NULL and dout_valid=0 on the next cycle.
REQ-020 In HOLD, the FSM SHALL wait indefinitely for dout_ready; the timeout counter is not active in HOLD.
REQ-021 In WAIT_NULL: ko=0; EMPTY on 2 consecutive cycles SHALL return the FSM to WAIT_DATA.
REQ-022 A 16-bit saturating counter SHALL clear on every state entry and increment each cycle in WAIT_DATA or WAIT_NULL.
REQ-023 When the counter reaches TIMEOUT, the block SHALL set err_timeout and go to FAULT.
REQ-024 Any ILLEGAL bit in WAIT_DATA or WAIT_NULL SHALL set err_illegal and go to FAULT; ILLEGAL takes priority over completion and timeout in the same cycle.
REQ-025 ILLEGAL bits seen in HOLD SHALL be ignored.
REQ-026 In FAULT: ko=0 and dout_valid=0; FAULT SHALL be exited only by reset.
REQ-027 Decoding SHALL map dout[i] = rail1 of bit i for COMPLETE words only.
REQ-028 Latency from din going COMPLETE to dout_valid=1 SHALL be SYNC_STAGES+2 cycles.

Reset
REQ-029 While rst_n=0 at an edge, the block SHALL enter WAIT_DATA with ko=1, dout=0, dout_valid=0, err_illegal=0, err_timeout=0, the counter at 0, and the synchronizers at 0 (NULL).
REQ-030 Reset asserted mid-HOLD SHALL drop the word without a transfer; din need not be NULL when reset is released.

Structure
REQ-031 The dual_rail_logic typedef (rail1, rail0), the DR_NULL/DR_ONE/DR_ZERO/DR_ILLEGAL constants and the FSM state enum SHALL live in the shared NCL package.
REQ-032 The per-bit synchronize-and-classify logic SHALL be one sub-module, ncl_dr_sync, instantiated WIDTH times.

Verification
REQ-033 After reset, din=all 01 except bit0=10 (held, dout_ready=1) -> dout=6'b000001 with a one-cycle dout_valid pulse, then ko=0.
REQ-034 Then din=all 00 -> ko=1 within SYNC_STAGES+2 cycles; a second word 6'b100100 decodes correctly.
REQ-035 With dout_ready=0 for 20 cycles -> dout_valid held at 1, dout stable, ko=1; raising dout_ready gives exactly one transfer.
REQ-036 Bit3=11 while in WAIT_DATA -> err_illegal=1, ko=0, FAULT persists until rst_n=0.
REQ-037 With TIMEOUT=8 and din PARTIAL (bit5=00, others DATA) -> err_timeout=1 after 8 cycles in WAIT_DATA, and err_illegal stays 0.
REQ-038 Bits driven COMPLETE one per cycle (skewed arrival) -> no error, and dout equals the final word only.
